// File: rtl/pipe_stage_reg_if.sv
// Bundle of the upstream (in_*) and downstream (out_*) handshake/payload signals
// around one pipeline stage register.
//   slave  : the stage itself (takes in_* and out_ready, drives in_ready and out_*)
//   master : the surrounding pipeline (drives in_* and out_ready, sees the rest)
interface pipe_stage_reg_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned EXC_W  = 5
);
  localparam int unsigned PC_W = 32;

  // Upstream side
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_instr;
  logic [PC_W-1:0]   in_pc;
  logic [EXC_W-1:0]  in_exccode;
  logic              in_isdelay;

  // Downstream side
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [PC_W-1:0]   out_pc;
  logic [PC_W-1:0]   out_pcplus4;
  logic [EXC_W-1:0]  out_exccode;
  logic              out_isdelay;
  logic [1:0]        out_count;

  modport slave (
    input  in_valid, in_instr, in_pc, in_exccode, in_isdelay, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_pcplus4, out_exccode,
           out_isdelay, out_count
  );

  modport master (
    output in_valid, in_instr, in_pc, in_exccode, in_isdelay, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_pcplus4, out_exccode,
           out_isdelay, out_count
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Two-entry (head + skid) in-order pipeline stage register with exception
// redirect and flush.
//   clk   : sole clock, rising edge
//   reset : asynchronous, active-low
//   req   : exception redirect - kill contents, load handler bubble at head
//   flush : kill contents, no bubble
//   bus   : pipe_stage_reg_if.slave (in_* upstream, out_* downstream, out_count)
// in_ready depends on the state register only, so the upstream never sees a
// combinational path from out_ready. DATA_W/EXC_W must match the interface.
module pipe_stage_reg #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned EXC_W      = 5,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req,
  input  logic            flush,
  pipe_stage_reg_if.slave bus
);

  localparam int unsigned PC_W = 32;

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [PC_W-1:0]   pc;
    logic [EXC_W-1:0]  exccode;
    logic              isdelay;
  } entry_t;

  // Encoding doubles as the occupancy count
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  localparam entry_t HANDLER_ENTRY = '{
    instr:   '0,
    pc:      HANDLER_PC,
    exccode: '0,
    isdelay: 1'b0
  };

  state_e          r_state;
  entry_t          r_head;
  entry_t          r_skid;
  logic [PC_W-1:0] r_head_pcplus4;

  state_e          w_state_nxt;
  entry_t          w_head_nxt;
  entry_t          w_skid_nxt;
  logic [PC_W-1:0] w_head_pcplus4_nxt;
  entry_t          w_in_entry;
  logic            w_in_ready;
  logic            w_out_valid;
  logic            w_accept;
  logic            w_retire;

  // Handshake decode, from state only
  assign w_in_ready  = (r_state != S_FULL);
  assign w_out_valid = (r_state != S_EMPTY);
  assign w_accept    = bus.in_valid && w_in_ready;
  assign w_retire    = w_out_valid && bus.out_ready;

  assign w_in_entry = '{
    instr:   bus.in_instr,
    pc:      bus.in_pc,
    exccode: bus.in_exccode,
    isdelay: bus.in_isdelay
  };

  // Next-state / next-contents: req > flush > handshake
  always_comb begin
    w_state_nxt = r_state;
    w_head_nxt  = r_head;
    w_skid_nxt  = r_skid;

    if (req) begin
      w_state_nxt = S_ONE;
      w_head_nxt  = HANDLER_ENTRY;
      w_skid_nxt  = '0;
    end else if (flush) begin
      w_state_nxt = S_EMPTY;
      w_head_nxt  = '0;
      w_skid_nxt  = '0;
    end else begin
      unique case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            w_state_nxt = S_ONE;
            w_head_nxt  = w_in_entry;
          end
        end
        S_ONE: begin
          if (w_accept && w_retire) begin
            w_head_nxt = w_in_entry;
          end else if (w_accept) begin
            w_state_nxt = S_FULL;
            w_skid_nxt  = w_in_entry;
          end else if (w_retire) begin
            w_state_nxt = S_EMPTY;
            w_head_nxt  = '0;
          end
        end
        S_FULL: begin
          // in_ready is low here, so only a retire can happen
          if (w_retire) begin
            w_state_nxt = S_ONE;
            w_head_nxt  = r_skid;
            w_skid_nxt  = '0;
          end
        end
        default: begin
          w_state_nxt = S_EMPTY;
          w_head_nxt  = '0;
          w_skid_nxt  = '0;
        end
      endcase
    end

    // pc+4 is precomputed so out_pcplus4 comes straight from a flop
    w_head_pcplus4_nxt = (w_state_nxt == S_EMPTY) ? '0
                                                  : w_head_nxt.pc + PC_W'(4);
  end

  // State and storage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= S_EMPTY;
      r_head         <= '0;
      r_skid         <= '0;
      r_head_pcplus4 <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_head         <= w_head_nxt;
      r_skid         <= w_skid_nxt;
      r_head_pcplus4 <= w_head_pcplus4_nxt;
    end
  end

  // Head fields are cleared whenever the stage empties, so they read 0 when idle
  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = w_out_valid;
  assign bus.out_instr   = r_head.instr;
  assign bus.out_pc      = r_head.pc;
  assign bus.out_pcplus4 = r_head_pcplus4;
  assign bus.out_exccode = r_head.exccode;
  assign bus.out_isdelay = r_head.isdelay;
  assign bus.out_count   = 2'(r_state);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: streaming, backpressure, exception
// redirect, flush, pc wrap and asynchronous reset.
module tb_pipe_stage_reg;

  logic clk;
  logic reset;
  logic req;
  logic flush;

  int n_cmp = 0;
  int n_err = 0;

  pipe_stage_reg_if #(.DATA_W(32), .EXC_W(5)) bus ();

  pipe_stage_reg #(
    .DATA_W    (32),
    .EXC_W     (5),
    .HANDLER_PC(32'h0000_4180)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .req  (req),
    .flush(flush),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic [4:0] exc, input logic isd);
    bus.in_valid   = v;
    bus.in_instr   = instr;
    bus.in_pc      = pc;
    bus.in_exccode = exc;
    bus.in_isdelay = isd;
  endtask

  initial begin
    reset = 1'b0;
    req   = 1'b0;
    flush = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 5'h0, 1'b0);

    // Reset state
    #2;
    check("rst_count",    32'(bus.out_count), 32'd0);
    check("rst_valid",    32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready),  32'd1);
    check("rst_pc",       bus.out_pc,         32'h0);
    check("rst_pcplus4",  bus.out_pcplus4,    32'h0);
    #10 reset = 1'b1;
    tick();
    check("idle_count", 32'(bus.out_count), 32'd0);

    // Streaming: each pc appears one cycle later, occupancy stays 1
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'hA000_0000 + 32'(k), 32'h3000 + 32'(4 * k), 5'h0, 1'b0);
      tick();
      check("stream_pc",      bus.out_pc,         32'h3000 + 32'(4 * k));
      check("stream_pcplus4", bus.out_pcplus4,    32'h3004 + 32'(4 * k));
      check("stream_instr",   bus.out_instr,      32'hA000_0000 + 32'(k));
      check("stream_count",   32'(bus.out_count), 32'd1);
    end
    drive(1'b0, 32'h0, 32'h0, 5'h0, 1'b0);
    tick();
    check("drain_count", 32'(bus.out_count), 32'd0);
    check("drain_valid", 32'(bus.out_valid), 32'd0);
    check("drain_pc",    bus.out_pc,         32'h0);

    // Backpressure
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h1, 32'h3000, 5'h0, 1'b0);
    tick();
    check("bp_count1", 32'(bus.out_count), 32'd1);
    drive(1'b1, 32'h2, 32'h3004, 5'h0, 1'b0);
    tick();
    check("bp_count2",   32'(bus.out_count), 32'd2);
    check("bp_in_ready", 32'(bus.in_ready),  32'd0);
    check("bp_head",     bus.out_pc,         32'h3000);
    drive(1'b1, 32'h3, 32'h3008, 5'h0, 1'b0);
    tick();
    check("bp_full_hold_count", 32'(bus.out_count), 32'd2);
    check("bp_full_hold_head",  bus.out_pc,         32'h3000);
    drive(1'b0, 32'h0, 32'h0, 5'h0, 1'b0);
    bus.out_ready = 1'b1;
    tick();
    check("bp_drain1_pc",    bus.out_pc,         32'h3004);
    check("bp_drain1_instr", bus.out_instr,      32'h2);
    check("bp_drain1_count", 32'(bus.out_count), 32'd1);
    tick();
    check("bp_drain2_count", 32'(bus.out_count), 32'd0);

    // Exception redirect from FULL with an entry pending upstream
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h11, 32'h5000, 5'h3, 1'b1);
    tick();
    drive(1'b1, 32'h12, 32'h5004, 5'h4, 1'b0);
    tick();
    check("exc_pre_count", 32'(bus.out_count), 32'd2);
    drive(1'b1, 32'h13, 32'h6000, 5'h5, 1'b1);
    req = 1'b1;
    tick();
    req = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 5'h0, 1'b0);
    check("exc_count",   32'(bus.out_count), 32'd1);
    check("exc_pc",      bus.out_pc,         32'h4180);
    check("exc_pcplus4", bus.out_pcplus4,    32'h4184);
    check("exc_instr",   bus.out_instr,      32'h0);
    check("exc_code",    32'(bus.out_exccode), 32'h0);
    check("exc_isdelay", 32'(bus.out_isdelay), 32'h0);
    bus.out_ready = 1'b1;
    tick();
    check("exc_drain_count", 32'(bus.out_count), 32'd0);

    // Flush from ONE with a simultaneous accept
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h21, 32'h7000, 5'h0, 1'b0);
    tick();
    drive(1'b1, 32'h22, 32'h7004, 5'h0, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 5'h0, 1'b0);
    check("flush_valid", 32'(bus.out_valid), 32'd0);
    check("flush_count", 32'(bus.out_count), 32'd0);
    check("flush_pc",    bus.out_pc,         32'h0);

    // req and flush together behave as req
    drive(1'b1, 32'h31, 32'h7100, 5'h0, 1'b0);
    tick();
    drive(1'b1, 32'h32, 32'h7104, 5'h0, 1'b0);
    req   = 1'b1;
    flush = 1'b1;
    tick();
    req   = 1'b0;
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 5'h0, 1'b0);
    check("reqflush_count", 32'(bus.out_count), 32'd1);
    check("reqflush_pc",    bus.out_pc,         32'h4180);
    bus.out_ready = 1'b1;
    tick();

    // Head holds under stall; in_valid toggling without handshake is harmless
    bus.out_ready = 1'b0;
    drive(1'b1, 32'hDEAD_BEEF, 32'h8000, 5'h1F, 1'b1);
    tick();
    drive(1'b0, 32'h0, 32'h9999, 5'h0, 1'b0);
    tick();
    tick();
    check("hold_count",   32'(bus.out_count),   32'd1);
    check("hold_instr",   bus.out_instr,        32'hDEAD_BEEF);
    check("hold_pc",      bus.out_pc,           32'h8000);
    check("hold_exc",     32'(bus.out_exccode), 32'h1F);
    check("hold_isdelay", 32'(bus.out_isdelay), 32'h1);
    bus.out_ready = 1'b1;
    tick();

    // PC wrap
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h41, 32'hFFFF_FFFC, 5'h0, 1'b0);
    tick();
    check("wrap_pc",      bus.out_pc,      32'hFFFF_FFFC);
    check("wrap_pcplus4", bus.out_pcplus4, 32'h0000_0000);

    // Async reset while FULL, between edges
    drive(1'b1, 32'h42, 32'h0000_1000, 5'h2, 1'b0);
    tick();
    check("prerst_count", 32'(bus.out_count), 32'd2);
    #1 reset = 1'b0;
    #1;
    check("arst_count",    32'(bus.out_count), 32'd0);
    check("arst_valid",    32'(bus.out_valid), 32'd0);
    check("arst_in_ready", 32'(bus.in_ready),  32'd1);
    check("arst_pc",       bus.out_pc,         32'h0);
    check("arst_pcplus4",  bus.out_pcplus4,    32'h0);
    drive(1'b1, 32'h51, 32'h2000, 5'h0, 1'b0);
    tick();
    check("rst_no_accept", 32'(bus.out_count), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    check("post_rst_count", 32'(bus.out_count), 32'd1);
    check("post_rst_pc",    bus.out_pc,         32'h2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, instruction/payload width.
REQ-002 SHALL have parameter EXC_W, default 5, exception-code width.
REQ-003 SHALL have parameter HANDLER_PC, default 32'h0000_4180, PC loaded on exception request.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  upstream entry present.
REQ-007 SHALL have port in_ready  output  1  stage accepts an entry this cycle.
REQ-008 SHALL have port in_instr  input  DATA_W  instruction word.
REQ-009 SHALL have port in_pc  input  32  PC of the instruction.
REQ-010 SHALL have port in_exccode  input  EXC_W  exception code carried forward.
REQ-011 SHALL have port in_isdelay  input  1  delay-slot flag.
REQ-012 SHALL have port req  input  1  exception redirect: kill contents, insert handler bubble.
REQ-013 SHALL have port flush  input  1  kill contents, no bubble.
REQ-014 SHALL have port out_valid  output  1  head entry valid.
REQ-015 SHALL have port out_ready  input  1  downstream consumes the head entry.
REQ-016 SHALL have ports out_instr (DATA_W), out_pc (32), out_pcplus4 (32), out_exccode (EXC_W), out_isdelay (1), all outputs, fields of the head entry.
REQ-017 SHALL have port out_count  output  2  occupancy, 0..2.

Function
REQ-018 SHALL hold a 2-entry in-order buffer (main + skid); FSM states EMPTY, ONE, FULL, encoded by out_count 0/1/2.
REQ-019 SHALL drive in_ready = (state != FULL), decoded from state only, with no combinational path from out_ready.
REQ-020 SHALL accept an entry when in_valid && in_ready, and retire the head when out_valid && out_ready, at the same rising edge.
REQ-021 SHALL drive out_valid = (state != EMPTY); when EMPTY, all out_* data fields SHALL read 0.
REQ-022 Transitions: EMPTY + accept -> ONE; ONE + accept only -> FULL; ONE + retire only -> EMPTY; ONE + accept + retire -> ONE with the new entry at head; FULL + retire -> ONE with the skid entry promoted to head.
REQ-023 SHALL hold the head fields stable while out_valid && !out_ready.
REQ-024 SHALL compute out_pcplus4 = out_pc + 4, modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
REQ-025 req SHALL override all other activity: at the edge, every entry is discarded, any concurrent accept is dropped, and the head is loaded with instr 0, pc HANDLER_PC, exccode 0, isdelay 0; next state ONE.
REQ-026 flush (with req low) SHALL discard all entries and drop any concurrent accept; next state EMPTY.
REQ-027 Priority SHALL be reset > req > flush > normal handshake.
REQ-028 in_ready SHALL remain decoded from state during req/flush cycles; the upstream handshake is considered complete, but the entry is dropped.
REQ-029 in_valid or out_ready toggling with no completed handshake SHALL NOT change state.

Reset
REQ-030 On reset low, the block SHALL immediately (asynchronously) set state EMPTY, out_valid 0, all out_* fields 0, out_count 0, in_ready 1.
REQ-031 Deassertion of reset SHALL take effect at the first rising clk edge after reset goes high; no accept SHALL occur while reset is low.
REQ-032 A reset asserted mid-transfer SHALL discard all entries without regard to req, flush, or the handshakes.

Verification
REQ-033 Streaming: in_valid=1 and out_ready=1 every cycle, pc 0x3000, 0x3004, ... -> each pc appears on out_pc exactly 1 cycle later, out_count stays 1, and out_pcplus4 = pc + 4.
REQ-034 Backpressure: out_ready=0, send pc 0x3000 then 0x3004 -> out_count reaches 2, in_ready=0, head holds 0x3000; raising out_ready drains 0x3000 then 0x3004 in order.
REQ-035 Exception: state FULL with in_valid=1, pulse req -> next cycle out_count=1, out_pc=0x4180, out_pcplus4=0x4184, out_instr=0, exccode 0, and the incoming entry is lost.
REQ-036 Flush: state ONE with a simultaneous accept, pulse flush -> next cycle out_valid=0, out_count=0; req+flush together -> the req behaviour of REQ-035.
REQ-037 Wrap and reset: in_pc 0xFFFF_FFFC -> out_pcplus4 = 0x0000_0000; driving reset low between clock edges while FULL -> outputs read 0 with no clock edge, and in_ready=1.
